// File: rtl/io_reg_pkg.sv
// Shared encodings for the io_register_bank_output slice.
// Op 2'b11 means TOGGLE, or PULSE when IO_REG_PULSE_EN is defined.
package io_reg_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_WRITE  = 2'b00;
   localparam op_t OP_SET    = 2'b01;
   localparam op_t OP_CLEAR  = 2'b10;
   localparam op_t OP_TOGGLE = 2'b11;
   localparam op_t OP_PULSE  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_e;

endpackage

// File: rtl/io_register_bank_output_if.sv
// Request side of the register bank bus: select, op, address and write data.
interface io_register_bank_output_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 2
);
   import io_reg_pkg::*;

   logic                  enable;
   logic                  write;
   op_t                   op;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_in;

   modport master (output enable, write, op, addr, data_in);
   modport slave  (input  enable, write, op, addr, data_in);

endinterface

// File: rtl/io_reg_pulse_timer.sv
// Per-register pulse down-counter; exists only when IO_REG_PULSE_EN is defined.
// expire strobes on the edge where the count goes from 1 to 0.
`ifdef IO_REG_PULSE_EN
module io_reg_pulse_timer #(
   parameter int unsigned PULSE_CYCLES = 16
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic load,
   input  logic cancel,
   output logic expire
);
   localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CntW'(PULSE_CYCLES);
      end else if (cancel) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Raw strobe; the bank lets a same-edge op override it.
   assign expire = (cnt_q == CntW'(1));

endmodule
`endif

// File: rtl/io_register_bank_output.sv
// Bank of output registers with set/clear/toggle ops and a one-op-per-enable handshake.
// Define IO_REG_PULSE_EN to turn op 2'b11 into a self-clearing PULSE.
module io_register_bank_output
   import io_reg_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH   = 32,
   parameter int unsigned          NUM_REGS     = 4,
   parameter int unsigned          ADDR_WIDTH   = 2,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned          PULSE_CYCLES = 16
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   io_register_bank_output_if.slave       bus,
   output wire  [DATA_WIDTH-1:0]          data_out,
   output wire                            ready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] mem_out
);

   if (NUM_REGS < 1 || (64'd1 << ADDR_WIDTH) < 64'(NUM_REGS) || PULSE_CYCLES < 1) begin : g_bad_cfg
      $error("io_register_bank_output: illegal parameter combination");
   end

   state_e                state_q, state_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  start;

   assign start = (state_q == ST_IDLE) && bus.enable;

`ifdef IO_REG_PULSE_EN
   logic [DATA_WIDTH-1:0] mask_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] mask_d [NUM_REGS];
   logic [NUM_REGS-1:0]   load, cancel, expire;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_timer
      io_reg_pulse_timer #(
         .PULSE_CYCLES(PULSE_CYCLES)
      ) u_timer (
         .clk_in (clk_in),
         .rst_in (rst_in),
         .load   (load[i]),
         .cancel (cancel[i]),
         .expire (expire[i])
      );
   end
`endif

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      dout_d  = dout_q;
      regs_d  = regs_q;
`ifdef IO_REG_PULSE_EN
      mask_d  = mask_q;
      load    = '0;
      cancel  = '0;
`endif
      if (state_q == ST_ACK) begin
         if (!bus.enable) begin
            state_d = ST_IDLE;
            ready_d = 1'b0;
         end
      end else if (bus.enable) begin
         state_d = ST_ACK;
         ready_d = 1'b1;
         dout_d  = '0;  // stays 0 for an unmapped address
      end

      for (int i = 0; i < NUM_REGS; i++) begin
`ifdef IO_REG_PULSE_EN
         if (expire[i]) begin
            regs_d[i] = regs_q[i] & ~mask_q[i];
            mask_d[i] = '0;
         end
`endif
         // Ops compute from regs_q, so a same-edge op overrides any expiry.
         if (start && 32'(bus.addr) == 32'(i)) begin
            if (bus.write) begin
               unique case (bus.op)
                  OP_WRITE: regs_d[i] = bus.data_in;
                  OP_SET:   regs_d[i] = regs_q[i] | bus.data_in;
                  OP_CLEAR: regs_d[i] = regs_q[i] & ~bus.data_in;
                  default: begin
`ifdef IO_REG_PULSE_EN
                     regs_d[i] = regs_q[i] | bus.data_in;
                     mask_d[i] = mask_q[i] | bus.data_in;
                     load[i]   = 1'b1;
`else
                     regs_d[i] = regs_q[i] ^ bus.data_in;
`endif
                  end
               endcase
`ifdef IO_REG_PULSE_EN
               if (bus.op != OP_PULSE) begin
                  mask_d[i] = '0;
                  cancel[i] = 1'b1;
               end
`endif
            end
            dout_d = regs_d[i];
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         dout_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VALUE;
`ifdef IO_REG_PULSE_EN
            mask_q[i] <= '0;
`endif
         end
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         dout_q  <= dout_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
`ifdef IO_REG_PULSE_EN
            mask_q[i] <= mask_d[i];
`endif
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_mem_out
      assign mem_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
   end

   assign ready    = bus.enable ? ready_q : 1'bz;
   assign data_out = bus.enable ? dout_q  : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_io_register_bank_output.sv
// Directed bench for io_register_bank_output; pulse checks build only with IO_REG_PULSE_EN.
module tb_io_register_bank_output;
   import io_reg_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 4;
   localparam int unsigned AW = 3;
   localparam logic [31:0] RV = 32'hA5A5_0000;

   logic           clk_in = 1'b0;
   logic           rst_in = 1'b0;
   wire  [DW-1:0]  data_out;
   wire            ready;
   logic [127:0]   mem_out;

   int   n_cmp   = 0;
   int   n_err   = 0;
   logic mon_on  = 1'b0;
   int   mon_cnt = 0;

   io_register_bank_output_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   io_register_bank_output #(
      .DATA_WIDTH   (DW),
      .NUM_REGS     (NR),
      .ADDR_WIDTH   (AW),
      .RESET_VALUE  (RV),
      .PULSE_CYCLES (16)
   ) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .bus      (bus),
      .data_out (data_out),
      .ready    (ready),
      .mem_out  (mem_out)
   );

   always #5 clk_in = ~clk_in;

   // Counts sampled cycles with mem_out bit 0 high.
   always @(posedge clk_in) begin
      #1;
      if (mon_on && mem_out[0]) mon_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_start(input logic w, input op_t o, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      @(negedge clk_in);
      bus.enable  = 1'b1;
      bus.write   = w;
      bus.op      = o;
      bus.addr    = a;
      bus.data_in = d;
   endtask

   task automatic bus_end();
      @(negedge clk_in);
      bus.enable = 1'b0;
   endtask

   // One transaction with enable held for `hold` edges; returns sampled data_out/ready.
   task automatic txn(input logic w, input op_t o, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int hold,
                      output logic [DW-1:0] rd, output logic rdy);
      bus_start(w, o, a, d);
      @(posedge clk_in);
      #1;
      rd  = data_out;
      rdy = (ready === 1'b1);
      repeat (hold - 1) @(posedge clk_in);
      bus_end();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic          rdy;
      logic          all_rdy;

      bus.enable  = 1'b0;
      bus.write   = 1'b0;
      bus.op      = OP_WRITE;
      bus.addr    = '0;
      bus.data_in = '0;

      #1 rst_in = 1'b1;
      #1;
      check("reset_mem_out", mem_out, {4{RV}});
      check("reset_ready_off", 128'(ready === 1'b1), 128'(0));
      @(negedge clk_in) rst_in = 1'b0;

      // WRITE addr2, with reset-state read data visible before the first edge
      bus_start(1'b1, OP_WRITE, 3'd2, 32'h0000_00F0);
      #1;
      check("pre_edge_ready", 128'(ready === 1'b1), 128'(0));
      check("reset_data_out", 128'(data_out), 128'(0));
      @(posedge clk_in);
      #1;
      check("write_ready", 128'(ready === 1'b1), 128'(1));
      check("write_data_out", 128'(data_out), 128'(32'h0000_00F0));
      bus_end();
      @(posedge clk_in);
      #1;

      txn(1'b1, OP_SET, 3'd2, 32'h0000_000F, 1, rd, rdy);
      check("set_ready", 128'(rdy), 128'(1));
      check("set_data_out", 128'(rd), 128'(32'h0000_00FF));
      check("set_mem_out", mem_out, {RV, 32'h0000_00FF, RV, RV});

      txn(1'b1, OP_CLEAR, 3'd2, 32'h0000_0011, 1, rd, rdy);
      check("clear_data_out", 128'(rd), 128'(32'h0000_00EE));
      txn(1'b1, OP_TOGGLE, 3'd2, 32'h8000_0001, 1, rd, rdy);
      check("toggle_data_out", 128'(rd), 128'(32'h8000_00EF));
      // Plain WRITE also stops any pulse the previous op may have started
      txn(1'b1, OP_WRITE, 3'd2, 32'h8000_00EF, 1, rd, rdy);
      txn(1'b0, OP_WRITE, 3'd2, 32'h0000_0000, 1, rd, rdy);
      check("read_addr2", 128'(rd), 128'(32'h8000_00EF));

`ifndef IO_REG_PULSE_EN
      txn(1'b1, OP_TOGGLE, 3'd3, 32'hA5A5_000F, 1, rd, rdy);
      check("toggle_flip_both", 128'(rd), 128'(32'h0000_000F));
      txn(1'b1, OP_WRITE, 3'd3, RV, 1, rd, rdy);
`endif

      txn(1'b0, OP_WRITE, 3'd5, 32'h0000_0000, 1, rd, rdy);
      check("oob_read_data", 128'(rd), 128'(0));
      check("oob_read_ready", 128'(rdy), 128'(1));
      txn(1'b1, OP_WRITE, 3'd5, 32'hFFFF_FFFF, 1, rd, rdy);
      check("oob_write_data", 128'(rd), 128'(0));
      check("oob_write_mem", mem_out, {RV, 32'h8000_00EF, RV, RV});

      // Enable held 10 cycles; request changes during ACK must be ignored
      bus_start(1'b1, OP_WRITE, 3'd1, 32'h1234_5678);
      @(posedge clk_in);
      #1;
      rd          = data_out;
      all_rdy     = (ready === 1'b1);
      bus.op      = OP_SET;
      bus.addr    = 3'd0;
      bus.data_in = 32'hDEAD_BEEF;
      repeat (9) begin
         @(posedge clk_in);
         #1;
         if (ready !== 1'b1) all_rdy = 1'b0;
      end
      check("hold_data_out", 128'(rd), 128'(32'h1234_5678));
      check("hold_ready_high", 128'(all_rdy), 128'(1));
      check("hold_single_op", mem_out, {RV, 32'h8000_00EF, 32'h1234_5678, RV});
      bus_end();
      @(posedge clk_in);
      #1;

      // Reset in ACK with enable still high
      bus_start(1'b1, OP_WRITE, 3'd0, 32'h1111_1111);
      @(posedge clk_in);
      #1;
      check("rst_pre_mem", mem_out, {RV, 32'h8000_00EF, 32'h1234_5678, 32'h1111_1111});
      #2 rst_in = 1'b1;
      #1;
      check("rst_async_mem", mem_out, {4{RV}});
      check("rst_ready_clear", 128'(ready === 1'b1), 128'(0));
      @(negedge clk_in) rst_in = 1'b0;
      #1;
      check("rst_release_ready", 128'(ready === 1'b1), 128'(0));
      @(posedge clk_in);
      #1;
      check("rst_new_ready", 128'(ready === 1'b1), 128'(1));
      check("rst_new_data", 128'(data_out), 128'(32'h1111_1111));
      check("rst_new_mem", mem_out, {RV, RV, RV, 32'h1111_1111});
      bus_end();
      @(posedge clk_in);
      #1;

`ifdef IO_REG_PULSE_EN
      txn(1'b1, OP_WRITE, 3'd0, 32'h0000_0000, 1, rd, rdy);

      bus_start(1'b1, OP_PULSE, 3'd0, 32'h0000_0001);
      mon_cnt = 0;
      mon_on  = 1'b1;
      @(posedge clk_in);
      bus_end();
      repeat (30) @(posedge clk_in);
      #2 mon_on = 1'b0;
      check("pulse_length", 128'(mon_cnt), 128'(16));
      check("pulse_cleared", 128'(mem_out[0]), 128'(0));

      bus_start(1'b1, OP_PULSE, 3'd0, 32'h0000_0001);
      mon_cnt = 0;
      mon_on  = 1'b1;
      @(posedge clk_in);
      bus_end();
      repeat (9) @(posedge clk_in);
      bus_start(1'b1, OP_PULSE, 3'd0, 32'h0000_0001);
      @(posedge clk_in);
      bus_end();
      repeat (40) @(posedge clk_in);
      #2 mon_on = 1'b0;
      check("pulse_extended", 128'(mon_cnt), 128'(26));

      bus_start(1'b1, OP_PULSE, 3'd0, 32'h0000_0001);
      @(posedge clk_in);
      bus_end();
      repeat (4) @(posedge clk_in);
      bus_start(1'b1, OP_SET, 3'd0, 32'h0000_0001);
      @(posedge clk_in);
      bus_end();
      repeat (30) @(posedge clk_in);
      #1;
      check("pulse_cancelled", 128'(mem_out[0]), 128'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/io_register_bank_output.md
Name: io_register_bank_output

Overview:
- Parametrised bank of NUM_REGS output registers on the shared enable/write/ready bus.
- Each register continuously drives a slice of the external output vector (GPIO, driver enables, stepper control lines).
- Adds addressing, atomic set/clear/toggle ops, a registered one-transaction-per-enable handshake, and a configurable reset value.
- Pure output block: no external inputs are sampled.

Parameters:
- DATA_WIDTH, 32, width of each register and of data_in/data_out
- NUM_REGS, 4, number of registers (>=1)
- ADDR_WIDTH, 2, address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS
- RESET_VALUE, 0, value loaded into every register on reset
- PULSE_CYCLES, 16, pulse length in clk_in cycles (>=1); used only with IO_REG_PULSE_EN

Ports:
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  asynchronous reset, active-high
- enable  input  1  bus select; held high for the whole transaction
- write  input  1  1 = modify op, 0 = read only
- op  input  2  00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE (or PULSE, see Optional Feature)
- addr  input  ADDR_WIDTH  register index
- data_in  input  DATA_WIDTH  write data or bit mask
- data_out  output  DATA_WIDTH  registered read data; high-Z while enable=0
- ready  output  1  transaction acknowledge; high-Z while enable=0
- mem_out  output  NUM_REGS*DATA_WIDTH  register i drives bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (rst_in asserted, asynchronous):
  - all registers = RESET_VALUE
  - FSM = IDLE, internal ready flag = 0, data_out register = 0
  - mem_out = replicated RESET_VALUE immediately
- FSM IDLE -> ACK: at a clk_in edge with enable=1.
  - The op is applied at that same edge when write=1.
  - data_out register captures the post-op value of regs[addr].
- FSM ACK:
  - ready=1 while enable=1; exactly one op per enable assertion.
  - write, op, addr and data_in are ignored in ACK.
- FSM ACK -> IDLE: at the edge where enable=0; internal ready flag clears.
- Latency: ready and data_out are valid one cycle after enable is first sampled high. mem_out updates at the same edge.
- Ops (applied to regs[addr]):
  - WRITE: r = data_in
  - SET: r = r | data_in
  - CLEAR: r = r & ~data_in
  - TOGGLE: r = r ^ data_in
- Read (write=0): no register changes; data_out = regs[addr].
- addr >= NUM_REGS: write ignored, data_out = 0, handshake still completes normally.
- enable dropped in the same cycle it is first sampled: the op is still applied. ready pulses internally for one cycle but is invisible on the bus (high-Z).
- Reset during ACK: FSM returns to IDLE. If enable is still high after rst_in releases, a new transaction starts at the next edge.
- Back-to-back transactions need at least one cycle of enable=0 between them.
- Tri-state gating of ready/data_out uses the live enable input; everything else is registered.

Optional Feature:
- Macro: IO_REG_PULSE_EN
- With the macro defined, op 11 = PULSE:
  - r = r | data_in; the register's pulse mask |= data_in.
  - A per-register down-counter of width $clog2(PULSE_CYCLES+1) loads PULSE_CYCLES.
  - The counter decrements every cycle while nonzero.
  - On the edge it reaches 0, r = r & ~mask and mask = 0, so the bits are high for exactly PULSE_CYCLES cycles.
  - A PULSE to a register already pulsing ORs into its mask and reloads its counter.
  - WRITE, SET, CLEAR or TOGGLE to a pulsing register clears its mask and stops its counter; the op result stands.
  - If an expiry and an op on the same register land on the same edge, the op wins and the expiry is suppressed.
  - Reset clears all masks and counters.
- Without the macro, op 11 = TOGGLE and no counters or masks exist.

Decomposition:
- Shared package io_reg_pkg holds:
  - op encodings: OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE, OP_PULSE
  - FSM state encodings: ST_IDLE, ST_ACK
- Natural sub-module: io_reg_pulse_timer.
  - One instance per register, compiled only under IO_REG_PULSE_EN.
  - Inputs: load, cancel. Output: expire strobe.

Test Plan:
- Reset, RESET_VALUE=32'hA5A5_0000 -> mem_out is all slices A5A5_0000 before the first edge; ready and data_out are Z.
- WRITE addr=2 data=0000_00F0, then SET addr=2 data=0000_000F -> ready goes 1 one cycle after enable; data_out = 0000_00FF; mem_out slice 2 = 0000_00FF; other slices unchanged.
- CLEAR addr=2 mask=0000_0011, then TOGGLE addr=2 mask=8000_0001 -> register reads 8000_00EF.
- Read at addr=5 with NUM_REGS=4, and enable held 10 cycles on a write -> data_out=0 and no register changes; only one op is applied, and ready stays 1 until enable falls.
- rst_in asserted mid-ACK with enable still high -> registers return to RESET_VALUE asynchronously; a new transaction is acknowledged one cycle after rst_in releases.
- IO_REG_PULSE_EN, PULSE_CYCLES=16, PULSE addr=0 data=1 -> bit0 is high for exactly 16 cycles, then clears. A re-PULSE at cycle 10 extends it to 26 cycles total. A SET at cycle 5 cancels the expiry and bit0 stays 1.
